way_array: RTL and testbench

Parametrised multi-way storage array for the L1 cache data and tag paths. It replaces the single-way, single-field array with N ways behind one index and byte-masked writes into a selected way. It also adds a read-during-write bypass and a sequenced clear, so large arrays can map to RAM instead of needing a one-cycle flop reset. The cache controller reads all ways in parallel for hit/miss selection and writes one way per cycle.

---
 rtl/way_array_pkg.sv | 14 +
 rtl/way_array_way_bank.sv | 36 +++
 rtl/way_array.sv | 128 ++++++++++++
 tb/tb_way_array.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/way_array_pkg.sv
// Shared types and helpers for the multi-way storage array.
package way_array_pkg;

   typedef enum logic {CLEAR, RUN} array_state_t;

   localparam int BYTE_W = 8;

   function automatic logic [BYTE_W-1:0] byte_sel(input logic [BYTE_W-1:0] old_b,
                                                  input logic [BYTE_W-1:0] new_b,
                                                  input logic              en);
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/way_array_way_bank.sv
// One way of storage: num_sets x width, byte-enable write, registered read.
module way_bank
   import way_array_pkg::*;
#(
   parameter int s_index = 3,
   parameter int width   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [s_index-1:0]       waddr,
   input  logic [width/BYTE_W-1:0]  wmask,
   input  logic [width-1:0]         wdata,
   input  logic                     re,
   input  logic [s_index-1:0]       raddr,
   output logic [width-1:0]         q
);

   localparam int num_sets = 2**s_index;
   localparam int n_bytes  = width/BYTE_W;

   logic [width-1:0] mem [num_sets];

   // No reset on the storage itself so it can map onto a RAM macro.
   always_ff @(posedge clk) begin
      for (int b = 0; b < n_bytes; b++) begin
         if (we && wmask[b]) mem[waddr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else if (re) q <= mem[raddr];
   end

endmodule

// File: rtl/way_array.sv
// N-way storage array with sequenced clear and byte-masked writes.
// Define ARRAY_BYPASS_EN for write-first same-index read-during-write; default is read-first.
module way_array
   import way_array_pkg::*;
#(
   parameter int s_index  = 3,
   parameter int width    = 32,
   parameter int num_ways = 2,
   parameter int s_way    = (num_ways > 1) ? $clog2(num_ways) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        read,
   input  logic [s_index-1:0]          rindex,
   input  logic                        load,
   input  logic [s_index-1:0]          windex,
   input  logic [s_way-1:0]            wway,
   input  logic [width/8-1:0]          wmask,
   input  logic [width-1:0]            datain,
   output logic [num_ways*width-1:0]   dataout,
   output logic                        ready
);

   localparam int num_sets = 2**s_index;
   localparam int n_bytes  = width/BYTE_W;
   localparam logic [s_index:0] CLR_LAST = (s_index+1)'(num_sets - 1);

   array_state_t        state;
   logic [s_index:0]    clr_cnt;
   logic                run;
   logic                rd_en;
   logic                wr_en;
   logic [s_index-1:0]  waddr;
   logic [n_bytes-1:0]  bmask;
   logic [width-1:0]    wdata;

   assign run   = (state == RUN);
   assign rd_en = run && read && !rst;
   assign wr_en = run && load && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + (s_index+1)'(1);
               if (clr_cnt == CLR_LAST) begin
                  state <= RUN;
                  ready <= 1'b1;
               end
            end
            RUN: ;
            default: state <= CLEAR;
         endcase
      end
   end

   // During CLEAR the write port is borrowed to zero every way of one set per cycle.
   always_comb begin
      waddr = clr_cnt[s_index-1:0];
      bmask = '1;
      wdata = '0;
      if (run) begin
         waddr = windex;
         bmask = wmask;
         wdata = datain;
      end
   end

`ifdef ARRAY_BYPASS_EN
   logic                byp_hit;
   logic [s_way-1:0]    byp_way;
   logic [n_bytes-1:0]  byp_mask;
   logic [width-1:0]    byp_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         byp_hit  <= 1'b0;
         byp_way  <= '0;
         byp_mask <= '0;
         byp_data <= '0;
      end else if (rd_en) begin
         byp_hit  <= wr_en && (windex == rindex);
         byp_way  <= wway;
         byp_mask <= wmask;
         byp_data <= datain;
      end
   end
`endif

   for (genvar k = 0; k < num_ways; k++) begin : g_way
      logic             we;
      logic [width-1:0] q;

      assign we = !run || (wr_en && (num_ways == 1 || wway == s_way'(k)));

      way_bank #(
         .s_index (s_index),
         .width   (width)
      ) u_bank (
         .clk   (clk),
         .rst   (rst),
         .we    (we),
         .waddr (waddr),
         .wmask (bmask),
         .wdata (wdata),
         .re    (rd_en),
         .raddr (rindex),
         .q     (q)
      );

`ifdef ARRAY_BYPASS_EN
      logic [width-1:0] merged;
      for (genvar b = 0; b < n_bytes; b++) begin : g_byte
         assign merged[b*BYTE_W +: BYTE_W] =
            byte_sel(q[b*BYTE_W +: BYTE_W], byp_data[b*BYTE_W +: BYTE_W], byp_mask[b]);
      end
      assign dataout[k*width +: width] =
         (byp_hit && (num_ways == 1 || byp_way == s_way'(k))) ? merged : q;
`else
      assign dataout[k*width +: width] = q;
`endif
   end

endmodule

// File: tb/tb_way_array.sv
// Scoreboard bench for way_array: 2-way main instance plus a 4-way instance.
module tb_way_array;

   logic         clk;
   logic         rst;
   logic         read;
   logic [2:0]   rindex;
   logic         load;
   logic [2:0]   windex;
   logic [0:0]   wway;
   logic [3:0]   wmask;
   logic [31:0]  datain;
   logic [63:0]  dataout;
   logic         ready;

   logic         load4;
   logic [1:0]   wway4;
   logic [127:0] dataout4;
   logic         ready4;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl [8][2];
   logic [63:0] exp_q [$];
   logic [63:0] last_exp;

   way_array #(.s_index(3), .width(32), .num_ways(2)) u_dut (
      .clk(clk), .rst(rst), .read(read), .rindex(rindex), .load(load),
      .windex(windex), .wway(wway), .wmask(wmask), .datain(datain),
      .dataout(dataout), .ready(ready)
   );

   way_array #(.s_index(3), .width(32), .num_ways(4)) u_dut4 (
      .clk(clk), .rst(rst), .read(read), .rindex(rindex), .load(load4),
      .windex(windex), .wway(wway4), .wmask(wmask), .datain(datain),
      .dataout(dataout4), .ready(ready4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old_w;
      for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
      return r;
   endfunction

   task automatic step();
      logic sampled_rd;
      sampled_rd = read && ready && !rst;
      @(posedge clk);
      #1;
      if (sampled_rd) begin
         if (exp_q.size() == 0) chk("sb_empty", 1, 0);
         else begin
            last_exp = exp_q.pop_front();
            chk("sb_read", dataout, last_exp);
         end
      end
   endtask

   task automatic issue(input logic rd, input logic [2:0] ri, input logic ld, input logic [2:0] wi,
                        input logic ww, input logic [3:0] wm, input logic [31:0] d);
      logic [63:0] e;
      read = rd; rindex = ri; load = ld; windex = wi; wway = ww; wmask = wm; datain = d;
      if (ready && !rst) begin
         if (rd) begin
            e = {mdl[ri][1], mdl[ri][0]};
`ifdef ARRAY_BYPASS_EN
            if (ld && wi == ri) e[ww*32 +: 32] = merge(mdl[ri][ww], d, wm);
`endif
            exp_q.push_back(e);
         end
         if (ld) mdl[wi][ww] = merge(mdl[wi][ww], d, wm);
      end
      step();
      read = 1'b0;
      load = 1'b0;
   endtask

   task automatic clear_wait();
      int n;
      n = 0;
      while (!ready && n < 20) begin
         step();
         n++;
      end
      chk("clr_len", n, 8);
      chk("rdy4", ready4, 1);
      for (int s = 0; s < 8; s++) begin
         mdl[s][0] = '0;
         mdl[s][1] = '0;
      end
   endtask

   initial begin
      rst = 1'b1; read = 0; rindex = 0; load = 0; windex = 0; wway = 0;
      wmask = 0; datain = 0; load4 = 0; wway4 = 0; last_exp = '0;

      // clear sequence
      step(); step();
      chk("rst_ready", ready, 0);
      chk("rst_dout", dataout, 0);
      rst = 1'b0;
      clear_wait();
      for (int s = 0; s < 8; s++) issue(1, 3'(s), 0, 0, 0, 0, 0);

      // masked write
      issue(0, 0, 1, 5, 1, 4'b0101, 32'hAABBCCDD);
      issue(1, 5, 0, 0, 0, 0, 0);
      chk("mask_w1", dataout[63:32], 32'h00BB00DD);
      chk("mask_w0", dataout[31:0], 0);

      // read during write
      issue(0, 0, 1, 2, 0, 4'hF, 32'h11111111);
      issue(1, 2, 1, 2, 0, 4'hF, 32'h22222222);
`ifdef ARRAY_BYPASS_EN
      chk("rdw_same", dataout[31:0], 32'h22222222);
`else
      chk("rdw_same", dataout[31:0], 32'h11111111);
`endif
      issue(1, 2, 0, 0, 0, 0, 0);
      chk("rdw_next", dataout[31:0], 32'h22222222);

      // hold with read low
      issue(1, 5, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold", dataout, last_exp);
      end

      // way independence on the 4-way instance
      for (int k = 0; k < 4; k++) begin
         load4 = 1'b1; windex = 3'd7; wway4 = 2'(k); wmask = 4'hF; datain = 32'(k + 1);
         step();
      end
      load4 = 1'b0;
      issue(1, 7, 0, 0, 0, 0, 0);
      chk("ways4", dataout4, {32'h4, 32'h3, 32'h2, 32'h1});

      // reset mid-clear, with a load and read attempted during clear
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      load = 1'b1; windex = 3'd1; wway = 1'b1; wmask = 4'hF; datain = 32'hFFFFFFFF;
      read = 1'b1; rindex = 3'd5;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("mid_rdy", ready, 0);
      end
      chk("clr_dout", dataout, 0);
      load = 1'b0; read = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_wait();
      issue(1, 1, 0, 0, 0, 0, 0);
      chk("clr_load", dataout, 0);

      // random traffic
      for (int i = 0; i < 60; i++) begin
         issue(1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)),
               3'($urandom_range(7)), 1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
      end
      step();
      chk("sb_drain", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
